mdu_core: RTL and testbench

Multiply/divide unit in the EX stage of the five-stage MIPS pipeline. It consumes the `start_E` / `MDUop_E` / operand fields delivered by the ID/EX pipeline register. It runs MULT/MULTU/DIV/DIVU as multi-cycle operations against private HI/LO registers, and serves MTHI/MTLO/MFHI/MFLO in a single cycle. It reports `busy` so the hazard unit can stall MDU instructions in ID.

---
 rtl/mdu_core.sv | 136 +++++++++++++
 tb/tb_mdu_core.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_core.sv
// Multiply/divide unit for the EX stage: MULT/MULTU/DIV/DIVU run against private HI/LO,
// with the result computed at launch and committed when the busy countdown expires.
module mdu_core #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  mduop,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam logic [5:0] OP_MULT  = 6'd1;
  localparam logic [5:0] OP_MULTU = 6'd2;
  localparam logic [5:0] OP_DIV   = 6'd3;
  localparam logic [5:0] OP_DIVU  = 6'd4;
  localparam logic [5:0] OP_MTHI  = 6'd5;
  localparam logic [5:0] OP_MTLO  = 6'd6;
  localparam logic [5:0] OP_MFHI  = 6'd7;
  localparam logic [5:0] OP_MFLO  = 6'd8;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [31:0] hi_nx_reg, hi_nx_next;
  logic [31:0] lo_nx_reg, lo_nx_next;
  logic        dz_reg, dz_next;

  logic        is_mul, is_div, launch, signed_op;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] prod_mag, prod;
  logic [31:0] quo_mag, rem_mag, quo, rem;

  assign is_mul    = (mduop == OP_MULT) || (mduop == OP_MULTU);
  assign is_div    = (mduop == OP_DIV)  || (mduop == OP_DIVU);
  assign launch    = (state_reg == IDLE) && start && (is_mul || is_div);
  assign signed_op = (mduop == OP_MULT) || (mduop == OP_DIV);

  // Sign-magnitude datapath: one unsigned multiplier/divider serves both signednesses,
  // and it keeps 0x80000000 / -1 well defined (magnitude 0x80000000 passes straight through).
  assign a_neg    = signed_op & rs_val[31];
  assign b_neg    = signed_op & rt_val[31];
  assign a_mag    = a_neg ? (32'd0 - rs_val) : rs_val;
  assign b_mag    = b_neg ? (32'd0 - rt_val) : rt_val;
  assign prod_mag = {32'd0, a_mag} * {32'd0, b_mag};
  assign prod     = (a_neg ^ b_neg) ? (64'd0 - prod_mag) : prod_mag;
  assign quo_mag  = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign rem_mag  = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign quo      = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
  assign rem      = a_neg ? (32'd0 - rem_mag) : rem_mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      hi_nx_reg <= 32'd0;
      lo_nx_reg <= 32'd0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      hi_nx_reg <= hi_nx_next;
      lo_nx_reg <= lo_nx_next;
      dz_reg    <= dz_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (launch) state_next = RUN;
      RUN:     if (cnt_reg == 4'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    hi_nx_next = hi_nx_reg;
    lo_nx_next = lo_nx_reg;
    dz_next    = dz_reg;
    case (state_reg)
      IDLE: begin
        if (launch) begin
          cnt_next   = is_div ? DIV_CNT : MULT_CNT;
          dz_next    = is_div && (rt_val == 32'd0);
          hi_nx_next = is_div ? rem : prod[63:32];
          lo_nx_next = is_div ? quo : prod[31:0];
        end else if (!start && (mduop == OP_MTHI)) begin
          hi_next = rs_val;
        end else if (!start && (mduop == OP_MTLO)) begin
          lo_next = rs_val;
        end
      end
      RUN: begin
        cnt_next = cnt_reg - 4'd1;
        // A divide by zero still occupies the unit but leaves HI/LO untouched.
        if ((cnt_reg == 4'd1) && !dz_reg) begin
          hi_next = hi_nx_reg;
          lo_next = lo_nx_reg;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state_reg == RUN);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

  always_comb begin
    rd_data = 32'd0;
    if (mduop == OP_MFHI)      rd_data = hi_reg;
    else if (mduop == OP_MFLO) rd_data = lo_reg;
  end

endmodule

// File: tb/tb_mdu_core.sv
// Self-checking bench for mdu_core: random and directed operations against a
// 64-bit arithmetic reference model of HI/LO.
module tb_mdu_core;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  mduop;
  logic [31:0] rs_val, rt_val;
  logic        busy;
  logic [31:0] hi, lo, rd_data;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_hi, model_lo;

  always #5 clk = ~clk;

  mdu_core dut (
    .clk(clk), .reset(reset), .start(start), .mduop(mduop),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy),
    .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_cycles(input logic [5:0] op);
    return (op == 6'd1 || op == 6'd2) ? 5 : 10;
  endfunction

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO.
  function automatic void model_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int ia, ib;
    longint sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0] t;
    ia = a; ib = b; sa = ia; sb = ib; ua = {32'd0, a}; ub = {32'd0, b};
    case (op)
      6'd1: begin t = sa * sb; model_hi = t[63:32]; model_lo = t[31:0]; end
      6'd2: begin t = ua * ub; model_hi = t[63:32]; model_lo = t[31:0]; end
      6'd3: if (b != 0) begin
              sq = sa / sb; sr = sa % sb;
              t = sq; model_lo = t[31:0];
              t = sr; model_hi = t[31:0];
            end
      6'd4: if (b != 0) begin
              t = ua / ub; model_lo = t[31:0];
              t = ua % ub; model_hi = t[31:0];
            end
      6'd5: model_hi = a;
      6'd6: model_lo = a;
      default: ;
    endcase
  endfunction

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Launch one operation and return once busy has dropped (first cycle a new start is legal).
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic start_busy, output int nbusy, output bit leaked);
    nbusy = 0; leaked = 0;
    start = 1'b1; mduop = op; rs_val = a; rt_val = b;
    start_busy = busy;
    step;
    start = 1'b0; mduop = 6'd0; rs_val = $urandom; rt_val = $urandom;
    while (busy && nbusy < 40) begin
      nbusy++;
      if (hi !== model_hi || lo !== model_lo) leaked = 1;
      step;
    end
    rs_val = 32'd0; rt_val = 32'd0;
  endtask

  task automatic move_to(input logic [5:0] op, input logic [31:0] val);
    start = 1'b0; mduop = op; rs_val = val;
    step;
    mduop = 6'd0;
    model_op(op, val, 32'd0);
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; mduop = 6'd0; rs_val = 32'd0; rt_val = 32'd0;
    model_hi = 32'd0; model_lo = 32'd0;
    #12;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
    mduop = 6'd7; #1;
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_rd got=%h exp=0", rd_data); end
    mduop = 6'd0;
    #1 reset = 1'b1;
    step;
    $display("reset: busy=%b hi=%h lo=%h", busy, hi, lo);
  endtask

  task automatic test_mult;
    logic sb; int n; bit lk; logic [31:0] a, b;
    run_op(6'd1, 32'hFFFFFFFE, 32'd3, sb, n, lk);
    model_op(6'd1, 32'hFFFFFFFE, 32'd3);
    checks++; if (sb !== 1'b0) begin failures++; $display("FAIL mult_start_busy got=%b exp=0", sb); end
    checks++; if (n != 5) begin failures++; $display("FAIL mult_cycles got=%0d exp=5", n); end
    checks++; if (lk) begin failures++; $display("FAIL mult_early_hilo got=1 exp=0"); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_fixed got=%h/%h exp=ffffffff/fffffffa", hi, lo); end
    mduop = 6'd7; #1;
    checks++; if (rd_data !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_mfhi got=%h exp=ffffffff", rd_data); end
    mduop = 6'd0;
    $display("mult -2*3: cycles=%0d hi=%h lo=%h", n, hi, lo);
    run_op(6'd2, 32'hFFFFFFFE, 32'd3, sb, n, lk);
    model_op(6'd2, 32'hFFFFFFFE, 32'd3);
    checks++; if (n != 5 || hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL multu_fixed got=%0d %h/%h exp=5 00000002/fffffffa", n, hi, lo); end
    $display("multu: cycles=%0d hi=%h lo=%h", n, hi, lo);
    for (int i = 0; i < 6; i++) begin
      logic [5:0] op;
      op = 6'($urandom_range(1, 2)); a = $urandom; b = $urandom;
      run_op(op, a, b, sb, n, lk);
      model_op(op, a, b);
      checks++; if (n != 5 || lk || hi !== model_hi || lo !== model_lo) begin failures++; $display("FAIL mult_rand op=%0d a=%h b=%h got=%0d %h/%h exp=5 %h/%h", op, a, b, n, hi, lo, model_hi, model_lo); end
      $display("mult op=%0d a=%h b=%h hi=%h lo=%h", op, a, b, hi, lo);
    end
  endtask

  task automatic test_div;
    logic sb; int n; bit lk; logic [31:0] a, b;
    run_op(6'd3, 32'hFFFFFFF9, 32'd2, sb, n, lk);
    model_op(6'd3, 32'hFFFFFFF9, 32'd2);
    checks++; if (n != 10 || lk) begin failures++; $display("FAIL div_cycles got=%0d leak=%0d exp=10 0", n, lk); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_fixed got=%h/%h exp=ffffffff/fffffffd", hi, lo); end
    $display("div -7/2: cycles=%0d hi=%h lo=%h", n, hi, lo);
    run_op(6'd3, 32'h80000000, 32'hFFFFFFFF, sb, n, lk);
    model_op(6'd3, 32'h80000000, 32'hFFFFFFFF);
    checks++; if (hi !== 32'd0 || lo !== 32'h80000000) begin failures++; $display("FAIL div_overflow got=%h/%h exp=00000000/80000000", hi, lo); end
    $display("div overflow: hi=%h lo=%h", hi, lo);
    for (int i = 0; i < 8; i++) begin
      logic [5:0] op;
      op = 6'($urandom_range(3, 4)); a = $urandom;
      b = (i % 2 == 0) ? $urandom : $urandom_range(1, 300);
      if (i % 4 == 3) b = 32'd0 - b;
      run_op(op, a, b, sb, n, lk);
      model_op(op, a, b);
      checks++; if (n != 10 || lk || hi !== model_hi || lo !== model_lo) begin failures++; $display("FAIL div_rand op=%0d a=%h b=%h got=%0d %h/%h exp=10 %h/%h", op, a, b, n, hi, lo, model_hi, model_lo); end
      $display("div op=%0d a=%h b=%h hi=%h lo=%h", op, a, b, hi, lo);
    end
  endtask

  task automatic test_divu;
    logic sb; int n; bit lk;
    move_to(6'd5, 32'h12345678);
    move_to(6'd6, 32'h0BADF00D);
    run_op(6'd4, 32'd7, 32'd0, sb, n, lk);
    model_op(6'd4, 32'd7, 32'd0);
    checks++; if (n != 10) begin failures++; $display("FAIL divzero_cycles got=%0d exp=10", n); end
    checks++; if (hi !== 32'h12345678 || lo !== 32'h0BADF00D) begin failures++; $display("FAIL divzero_keep got=%h/%h exp=12345678/0badf00d", hi, lo); end
    $display("divu 7/0: cycles=%0d hi=%h lo=%h", n, hi, lo);
    run_op(6'd4, 32'd100, 32'd7, sb, n, lk);
    model_op(6'd4, 32'd100, 32'd7);
    checks++; if (hi !== 32'd2 || lo !== 32'd14) begin failures++; $display("FAIL divu_fixed got=%h/%h exp=2/14", hi, lo); end
    $display("divu 100/7: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_mid_events;
    int n; bit lk; logic [31:0] a, b;
    a = $urandom; b = $urandom_range(1, 5000);
    start = 1'b1; mduop = 6'd3; rs_val = a; rt_val = b;
    step;
    n = 0; lk = 0;
    for (int c = 1; c <= 40 && busy; c++) begin
      n++;
      if (hi !== model_hi || lo !== model_lo) lk = 1;
      start = 1'b0; mduop = 6'd0; rs_val = 32'd0; rt_val = 32'd0;
      if (c == 3) begin mduop = 6'd6; rs_val = 32'hAAAA; end
      if (c == 4) begin start = 1'b1; mduop = 6'd1; rs_val = 32'd9; rt_val = 32'd9; end
      if (c == 5) begin mduop = 6'd5; rs_val = 32'h5555; end
      step;
    end
    start = 1'b0; mduop = 6'd0;
    model_op(6'd3, a, b);
    checks++; if (n != 10 || lk) begin failures++; $display("FAIL mid_cycles got=%0d leak=%0d exp=10 0", n, lk); end
    checks++; if (hi !== model_hi || lo !== model_lo) begin failures++; $display("FAIL mid_result got=%h/%h exp=%h/%h", hi, lo, model_hi, model_lo); end
    step;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_relaunch got=%b exp=0", busy); end
    $display("mid events div a=%h b=%h: cycles=%0d hi=%h lo=%h", a, b, n, hi, lo);
  endtask

  task automatic test_reset_mid;
    move_to(6'd5, 32'hDEAD0001);
    move_to(6'd6, 32'hBEEF0002);
    start = 1'b1; mduop = 6'd3; rs_val = $urandom; rt_val = 32'd3;
    step;
    start = 1'b0; mduop = 6'd0;
    step; step; step;
    #3 reset = 1'b0;
    #1;
    model_hi = 32'd0; model_lo = 32'd0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL rstmid_hilo got=%h/%h exp=0/0", hi, lo); end
    #2 reset = 1'b1;
    for (int i = 0; i < 12; i++) step;
    checks++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL rstmid_after got=%b %h/%h exp=0 0/0", busy, hi, lo); end
    $display("reset mid-div: busy=%b hi=%h lo=%h", busy, hi, lo);
  endtask

  task automatic test_move_read;
    logic [31:0] old_lo;
    old_lo = model_lo;
    start = 1'b0; mduop = 6'd6; rs_val = 32'h55; #1;
    checks++; if (lo !== old_lo || rd_data !== 32'd0) begin failures++; $display("FAIL mtlo_same_cycle got=%h/%h exp=%h/0", lo, rd_data, old_lo); end
    step;
    model_op(6'd6, 32'h55, 32'd0);
    mduop = 6'd8; rs_val = 32'd0; #1;
    checks++; if (rd_data !== 32'h55) begin failures++; $display("FAIL mflo_after got=%h exp=00000055", rd_data); end
    mduop = 6'd5; rs_val = 32'hCAFE0000; #1;
    step;
    model_op(6'd5, 32'hCAFE0000, 32'd0);
    mduop = 6'd7; #1;
    checks++; if (rd_data !== model_hi) begin failures++; $display("FAIL mfhi_after got=%h exp=%h", rd_data, model_hi); end
    mduop = 6'd9; #1;
    checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL rd_other_op got=%h exp=0", rd_data); end
    mduop = 6'd0;
    step;
    $display("move/read: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_back_to_back;
    logic sb; int n; bit lk; logic [31:0] a, b; logic [5:0] op;
    for (int i = 0; i < 14; i++) begin
      op = 6'($urandom_range(1, 4)); a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 64));
      run_op(op, a, b, sb, n, lk);
      model_op(op, a, b);
      checks++; if (sb !== 1'b0 || n != exp_cycles(op) || lk || hi !== model_hi || lo !== model_lo) begin
        failures++;
        $display("FAIL b2b op=%0d a=%h b=%h got=%b %0d %0d %h/%h exp=0 %0d 0 %h/%h", op, a, b, sb, n, lk, hi, lo, exp_cycles(op), model_hi, model_lo);
      end
      $display("b2b op=%0d a=%h b=%h cycles=%0d hi=%h lo=%h", op, a, b, n, hi, lo);
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_divu;
    test_mid_events;
    test_reset_mid;
    test_move_read;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
